// File: rtl/bch_63_51_decoder.sv
// Serial BCH(63,51) t=2 decoder: syndromes, error-locator classification and Chien-search correction.
// First corrected bit is valid 4 cycles after bit 62 is accepted; in_ready drops only while a finished frame waits behind a busy output.
module bch_63_51_decoder #(
  parameter int N = 63,
  parameter int K = 51
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_data,
  output logic in_ready,
  output logic out_valid,
  output logic out_data,
  input  logic out_ready
);

  localparam logic [5:0] LAST_BIT = 6'(N - 1);
  localparam logic [5:0] MSG_BITS = 6'(K);
  localparam logic [5:0] LAST_OUT = 6'(K - 1);
  localparam logic [5:0] ALPHA    = 6'h02;
  localparam logic [5:0] ALPHA2   = 6'h04;
  localparam logic [5:0] ALPHA3   = 6'h08;

  function automatic logic [5:0] gf_xtime(input logic [5:0] a);
    return {a[4:0], 1'b0} ^ (a[5] ? 6'h03 : 6'h00);
  endfunction

  function automatic logic [5:0] gf_mul(input logic [5:0] a, input logic [5:0] b);
    logic [5:0] p;
    logic [5:0] aa;
    logic [5:0] bb;
    p  = '0;
    aa = a;
    bb = b;
    for (int i = 0; i < 6; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = gf_xtime(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // inverse of alpha^i is alpha^(63-i); entry 0 is unused and left 0
  function automatic logic [63:0][5:0] build_inv();
    logic [62:0][5:0] pw;
    logic [63:0][5:0] t;
    int               j;
    t     = '0;
    pw    = '0;
    pw[0] = 6'h01;
    for (int i = 1; i < 63; i++) pw[6'(i)] = gf_xtime(pw[6'(i - 1)]);
    for (int i = 0; i < 63; i++) begin
      j = (63 - i) % 63;
      t[pw[6'(i)]] = pw[6'(j)];
    end
    return t;
  endfunction

  localparam logic [63:0][5:0] INV_TBL = build_inv();

  typedef enum logic [2:0] {ST_IDLE, ST_CLS, ST_SIG, ST_ARM, ST_EMIT} state_t;

  state_t         state_q, state_d;
  logic [5:0]     cnt_q, cnt_d;
  logic [5:0]     s1_q, s1_d, s3_q, s3_d;
  logic [K-1:0]   rx_msg_q, rx_msg_d;
  logic           pend_vld_q, pend_vld_d;
  logic [K-1:0]   pend_msg_q, pend_msg_d;
  logic [5:0]     pend_s1_q, pend_s1_d, pend_s3_q, pend_s3_d;
  logic [K-1:0]   out_msg_q, out_msg_d;
  logic [5:0]     syn1_q, syn1_d, syn3_q, syn3_d;
  logic [5:0]     sig1_q, sig1_d, sig2_q, sig2_d;
  logic [5:0]     l1_q, l1_d, l2_q, l2_d;
  logic [5:0]     idx_q, idx_d;

  logic           in_rdy_int;
  logic           in_acc;
  logic           chien_hit;
  logic [5:0]     s1_prev, s3_prev;
  logic [5:0]     s1_sq, s1_cu, s3_div;

  assign in_rdy_int = ~(pend_vld_q & (state_q != ST_IDLE));
  assign in_ready   = rst | in_rdy_int;
  assign in_acc     = in_valid & in_rdy_int;
  assign chien_hit  = ((l1_q ^ l2_q) == 6'h01);
  assign out_valid  = ~rst & (state_q == ST_EMIT);
  assign out_data   = out_valid & (out_msg_q[K-1] ^ chien_hit);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    s1_d       = s1_q;
    s3_d       = s3_q;
    rx_msg_d   = rx_msg_q;
    pend_vld_d = pend_vld_q;
    pend_msg_d = pend_msg_q;
    pend_s1_d  = pend_s1_q;
    pend_s3_d  = pend_s3_q;
    out_msg_d  = out_msg_q;
    syn1_d     = syn1_q;
    syn3_d     = syn3_q;
    sig1_d     = sig1_q;
    sig2_d     = sig2_q;
    l1_d       = l1_q;
    l2_d       = l2_q;
    idx_d      = idx_q;
    s1_sq      = gf_mul(syn1_q, syn1_q);
    s1_cu      = gf_mul(s1_sq, syn1_q);
    s3_div     = gf_mul(syn3_q, INV_TBL[syn1_q]);
    s1_prev    = (cnt_q == 6'd0) ? 6'd0 : s1_q;
    s3_prev    = (cnt_q == 6'd0) ? 6'd0 : s3_q;

    case (state_q)
      ST_IDLE: begin
        if (pend_vld_q) begin
          state_d    = ST_CLS;
          pend_vld_d = 1'b0;
          out_msg_d  = pend_msg_q;
          syn1_d     = pend_s1_q;
          syn3_d     = pend_s3_q;
        end
      end
      ST_CLS: begin
        // S1=0 covers both the clean and the uncorrectable frame: a zero locator never hits
        state_d = ST_SIG;
        sig1_d  = syn1_q;
        sig2_d  = '0;
        if (syn1_q != 6'd0 && syn3_q != s1_cu) sig2_d = s3_div ^ s1_sq;
      end
      ST_SIG: begin
        state_d = ST_ARM;
        l1_d    = gf_mul(sig1_q, ALPHA);
        l2_d    = gf_mul(sig2_q, ALPHA2);
        idx_d   = '0;
      end
      ST_ARM: begin
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (out_ready) begin
          out_msg_d = {out_msg_q[K-2:0], 1'b0};
          l1_d      = gf_mul(l1_q, ALPHA);
          l2_d      = gf_mul(l2_q, ALPHA2);
          if (idx_q == LAST_OUT) begin
            state_d = ST_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (in_acc) begin
      s1_d = gf_mul(s1_prev, ALPHA) ^ {5'd0, in_data};
      s3_d = gf_mul(s3_prev, ALPHA3) ^ {5'd0, in_data};
      if (cnt_q < MSG_BITS) rx_msg_d = {rx_msg_q[K-2:0], in_data};
      if (cnt_q == LAST_BIT) begin
        cnt_d      = '0;
        pend_vld_d = 1'b1;
        pend_msg_d = rx_msg_q;
        pend_s1_d  = s1_d;
        pend_s3_d  = s3_d;
      end else begin
        cnt_d = cnt_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      s1_q       <= '0;
      s3_q       <= '0;
      rx_msg_q   <= '0;
      pend_vld_q <= 1'b0;
      pend_msg_q <= '0;
      pend_s1_q  <= '0;
      pend_s3_q  <= '0;
      out_msg_q  <= '0;
      syn1_q     <= '0;
      syn3_q     <= '0;
      sig1_q     <= '0;
      sig2_q     <= '0;
      l1_q       <= '0;
      l2_q       <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s1_q       <= s1_d;
      s3_q       <= s3_d;
      rx_msg_q   <= rx_msg_d;
      pend_vld_q <= pend_vld_d;
      pend_msg_q <= pend_msg_d;
      pend_s1_q  <= pend_s1_d;
      pend_s3_q  <= pend_s3_d;
      out_msg_q  <= out_msg_d;
      syn1_q     <= syn1_d;
      syn3_q     <= syn3_d;
      sig1_q     <= sig1_d;
      sig2_q     <= sig2_d;
      l1_q       <= l1_d;
      l2_q       <= l2_d;
      idx_q      <= idx_d;
    end
  end

endmodule

// File: tb/tb_bch_63_51_decoder.sv
// Directed bench for bch_63_51_decoder: clean, single, double, random, stalled and reset-interrupted frames.
module tb_bch_63_51_decoder;

  logic clk = 1'b0;
  logic rst, in_valid, in_data, in_ready, out_valid, out_data, out_ready;

  always #5 clk = ~clk;

  bch_63_51_decoder #(.N(63), .K(51)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [50:0] exp_q[$];
  logic [50:0] got_q[$];
  int          end_edges[$];
  int          acc62_cyc;
  int          start_cyc;
  int          out_bits;
  int          low_cnt;
  int          rise_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // systematic encoder: parity = m(x)*x^12 mod g(x), g low bits 12'h539
  function automatic logic [62:0] encode(input logic [50:0] m);
    logic [11:0] r;
    logic [50:0] mm;
    logic        fb;
    r  = '0;
    mm = m;
    for (int i = 0; i < 51; i++) begin
      fb = mm[50] ^ r[11];
      r  = {r[10:0], 1'b0} ^ (fb ? 12'h539 : 12'h000);
      mm = mm << 1;
    end
    return {m, r};
  endfunction

  task automatic send_frame(input logic [62:0] cw, input logic [50:0] m);
    logic [62:0] sh;
    int          guard;
    exp_q.push_back(m);
    sh = cw;
    for (int j = 62; j >= 0; j--) begin
      in_valid = 1'b1;
      in_data  = sh[62];
      guard    = 0;
      while (!in_ready && guard < 500) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 500) begin
        check("in_ready_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        return;
      end
      if (j == 0) acc62_cyc = cyc + 1;
      @(negedge clk);
      sh = sh << 1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int g;
    g = 0;
    while (got_q.size() < n && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (got_q.size() < n) check("frame_timeout", 64'(got_q.size()), 64'(n));
  endtask

  task automatic compare_frames(input string tag);
    while (got_q.size() > 0 && exp_q.size() > 0)
      check(tag, 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
    exp_q.delete();
    end_edges.delete();
  endtask

  // output collector: a bit counts only when out_valid and out_ready meet at a clock edge
  initial begin
    logic [50:0] fr;
    bit          started;
    fr       = '0;
    started  = 1'b0;
    out_bits = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        out_bits = 0;
        started  = 1'b0;
      end else if (out_valid) begin
        if (!started) begin
          start_cyc = cyc;
          started   = 1'b1;
        end
        if (out_ready) begin
          fr = {fr[49:0], out_data};
          out_bits++;
          if (out_bits == 51) begin
            got_q.push_back(fr);
            end_edges.push_back(cyc + 1);
            out_bits = 0;
            started  = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    bit prev_rdy;
    prev_rdy = 1'b1;
    low_cnt  = 0;
    rise_cyc = -1;
    forever begin
      @(negedge clk);
      if (!rst && !in_ready) low_cnt++;
      if (!rst && !prev_rdy && in_ready) rise_cyc = cyc;
      prev_rdy = in_ready;
    end
  end

  initial begin
    logic [62:0] cw;
    logic [50:0] m;
    logic [63:0] r64;
    logic [5:0]  p1, p2;
    int          nf, low_before;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    rst = 1'b0;

    // all-zero codeword
    send_frame(63'h0, 51'h0);
    wait_frames(1);
    check("t1_latency", 64'(start_cyc - acc62_cyc), 64'd4);
    compare_frames("t1_zero_frame");

    // m0=1 with hand parity 010100111001, error at r40
    cw = {50'h0, 1'b1, 12'b010100111001};
    cw[40] = ~cw[40];
    send_frame(cw, 51'h1);
    wait_frames(1);
    check("t2_latency", 64'(start_cyc - acc62_cyc), 64'd4);
    compare_frames("t2_single_err");

    // alternating message, errors in first message bit and last parity bit
    m  = 51'h5_5555_5555_5555;
    cw = encode(m);
    cw[62] = ~cw[62];
    cw[0]  = ~cw[0];
    send_frame(cw, m);
    wait_frames(1);
    compare_frames("t3_double_err");

    // both errors in parity bits
    m  = 51'h7_0F0F_1234_ABCD;
    cw = encode(m);
    cw[11] = ~cw[11];
    cw[5]  = ~cw[5];
    send_frame(cw, m);
    wait_frames(1);
    compare_frames("t3b_parity_errs");

    // 10 random back-to-back frames
    low_before = low_cnt;
    for (int f = 0; f < 10; f++) begin
      r64 = {$urandom, $urandom};
      m   = r64[50:0];
      cw  = encode(m);
      p1  = 6'($urandom_range(62, 0));
      p2  = 6'($urandom_range(62, 0));
      if (p2 == p1) p2 = (p1 == 6'd62) ? 6'd0 : p1 + 6'd1;
      nf  = int'($urandom_range(2, 0));
      if (nf >= 1) cw[p1] = ~cw[p1];
      if (nf == 2) cw[p2] = ~cw[p2];
      send_frame(cw, m);
    end
    wait_frames(10);
    check("t4_in_ready_held", 64'(low_cnt - low_before), 64'd0);
    compare_frames("t4_random_frame");

    // output stall while the next frame arrives
    low_before = low_cnt;
    fork
      begin
        m  = 51'h3_1415_9265_3589;
        cw = encode(m);
        cw[30] = ~cw[30];
        send_frame(cw, m);
        m  = 51'h2_7182_8182_8459;
        cw = encode(m);
        cw[50] = ~cw[50];
        cw[7]  = ~cw[7];
        send_frame(cw, m);
      end
      begin
        int g;
        g = 0;
        while (out_bits < 20 && g < 1000) begin
          @(posedge clk);
          #1;
          g++;
        end
        out_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("t5_hold_valid", 64'(out_valid), 64'd1);
        repeat (10) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_frames(2);
    check("t5_ready_dropped", 64'(low_cnt > low_before), 64'd1);
    if (end_edges.size() > 0) check("t5_ready_return", 64'(rise_cyc), 64'(end_edges[0]));
    else check("t5_ready_return", 64'(rise_cyc), 64'd0);
    compare_frames("t5_stall_frame");

    // reset in the middle of a frame, then a clean frame
    for (int j = 0; j < 30; j++) begin
      in_valid = 1'b1;
      in_data  = 1'($urandom_range(1, 0));
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_in_ready",  64'(in_ready),  64'd1);
    check("t6_rst_out_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;
    m  = 51'h2_3456_789A_BCDE;
    cw = encode(m);
    cw[20] = ~cw[20];
    send_frame(cw, m);
    wait_frames(1);
    repeat (100) @(negedge clk);
    check("t6_frame_count", 64'(got_q.size()), 64'd1);
    compare_frames("t6_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
